// File: rtl/key_schedule_ctrl_if.sv
// Bus bundle for the AES-128 key schedule controller:
// job request/status plus the round-key read port.
interface key_schedule_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    modport master (
        output start,
        output key_in,
        output rd_addr,
        input  busy,
        input  done,
        input  keys_valid,
        input  rd_data
    );

    modport slave (
        input  start,
        input  key_in,
        input  rd_addr,
        output busy,
        output done,
        output keys_valid,
        output rd_data
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion: one round per clock into an 11-entry
// round-key file, with a zero-latency indexed read port.
module key_generation (
    input  logic [127:0] key_in,
    input  logic [3:0]   round_num,
    output logic [127:0] key_out
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // S-box from the field inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] s;
        p = gf_mul(gf_mul(x, x), x);
        p = gf_mul(gf_mul(p, p), x);
        p = gf_mul(gf_mul(p, p), x);
        p = gf_mul(gf_mul(p, p), x);
        p = gf_mul(gf_mul(p, p), x);
        p = gf_mul(gf_mul(p, p), x);
        s = gf_mul(p, p);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]}
                 ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;

    always_comb begin
        case (round_num)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key_in;
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]),
                  sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};
endmodule

module key_schedule_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    key_schedule_ctrl_if.slave   bus
);
    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic [127:0] rk_q [11];
    logic [127:0] rk_d [11];
    logic         done_q;
    logic         done_d;
    logic         valid_q;
    logic         valid_d;
    logic [127:0] next_key;

    key_generation u_keygen (
        .key_in    (work_q),
        .round_num (rnd_q),
        .key_out   (next_key)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        work_d  = work_q;
        rk_d    = rk_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rk_d[0] = bus.key_in;
                    work_d  = bus.key_in;
                    rnd_d   = 4'd1;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i < 11; i++) begin
                    if (rnd_q == 4'(i)) rk_d[i] = next_key;
                end
                if (rnd_q == 4'd10) begin
                    rnd_d   = 4'd0;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    work_d = next_key;
                    rnd_d  = rnd_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            work_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            work_q  <= work_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
        end
    end

    // Read port is ungated: mid-expansion it shows partial contents
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.rd_addr == 4'(i)) bus.rd_data = rk_q[i];
        end
    end

    assign bus.busy       = (state_q == EXPAND);
    assign bus.done       = done_q;
    assign bus.keys_valid = valid_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Testbench for key_schedule_ctrl: known-answer table, random keys
// against a word-level FIPS-197 expansion model, and timing corners.
module tb_key_schedule_ctrl;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   mis_cnt;

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] model_rk [11];

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_TBL[int'(b) * 8 +: 8];
    endfunction

    // Textbook word recurrence w[i] = w[i-4] ^ f(w[i-1])
    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        int          rc;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        rc   = 1;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                t = t ^ {8'(rc), 24'h0};
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input logic [127:0] k);
        int n;
        bus.key_in = k;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.key_in = rnd_key();
        chk("busy_after_accept", 128'(bus.busy), 128'd1);
        chk("valid_drop", 128'(bus.keys_valid), 128'd0);
        n = 0;
        while (!bus.done && n < 30) begin
            tick();
            n++;
        end
        chk("done_latency", 128'(n), 128'd10);
        chk("valid_at_done", 128'(bus.keys_valid), 128'd1);
        expand(k);
        tick();
        chk("done_one_cycle", 128'(bus.done), 128'd0);
        chk("busy_idle", 128'(bus.busy), 128'd0);
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            chk($sformatf("%s_rk%0d", nm, a), bus.rd_data,
                (a <= 10) ? model_rk[a] : 128'h0);
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int           dcnt;
        int           d1;
        int           d2;
        logic [127:0] kb;
        logic [127:0] last_key;

        vec_cnt = 0;
        mis_cnt = 0;
        vt[0] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
        vt[1] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vt[2] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vt[3] = '{128'h0,   4'd1,  128'h62636363626363636263636362636363};
        vt[4] = '{128'h0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vt[5] = '{128'h0,   4'd0,  128'h0};
        vt[6] = '{128'h0,   4'd11, 128'h0};
        vt[7] = '{128'h0,   4'd15, 128'h0};

        // Reset with random inputs
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.key_in  = rnd_key();
        bus.rd_addr = 4'd0;
        repeat (3) tick();
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_valid", 128'(bus.keys_valid), 128'd0);
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            bus.key_in  = rnd_key();
            #1;
            chk($sformatf("rst_rd%0d", a), bus.rd_data, 128'h0);
        end
        bus.start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Known-answer table
        last_key = '1;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].key !== last_key) begin
                run_job(vt[i].key);
                last_key = vt[i].key;
            end
            bus.rd_addr = vt[i].addr;
            #1;
            chk($sformatf("kat%0d", i), bus.rd_data, vt[i].exp);
        end

        // Random keys against the model
        for (int j = 0; j < 12; j++) begin
            run_job(rnd_key());
            read_all($sformatf("rand%0d", j));
        end

        // Start during EXPAND is ignored
        bus.key_in = FIPS_KEY;
        bus.start  = 1'b1;
        tick();
        dcnt = 0;
        for (int t = 1; t <= 30; t++) begin
            bus.start  = (t == 5);
            bus.key_in = (t == 5) ? rnd_key() : 128'h0;
            tick();
            if (bus.done) dcnt++;
        end
        chk("ignore_done_count", 128'(dcnt), 128'd1);
        expand(FIPS_KEY);
        read_all("ignore");

        // Reset mid-expansion
        bus.key_in = rnd_key();
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_done", 128'(bus.done), 128'd0);
        chk("mid_rst_valid", 128'(bus.keys_valid), 128'd0);
        for (int a = 0; a < 11; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            chk($sformatf("mid_rst_rd%0d", a), bus.rd_data, 128'h0);
        end
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (bus.done || bus.busy) dcnt++;
        end
        chk("mid_rst_quiet", 128'(dcnt), 128'd0);
        kb = rnd_key();
        run_job(kb);
        read_all("restart");

        // Back-to-back with start held high
        kb = rnd_key();
        bus.key_in = rnd_key();
        bus.start  = 1'b1;
        tick();
        bus.key_in = kb;
        d1 = -1;
        d2 = -1;
        for (int t = 1; t <= 26; t++) begin
            tick();
            if (t == 11) bus.start = 1'b0;
            if (bus.done) begin
                if (d1 < 0) d1 = t;
                else if (d2 < 0) d2 = t;
            end
            if (t >= 11 && t <= 20)
                chk($sformatf("b2b_valid_low%0d", t),
                    128'(bus.keys_valid), 128'd0);
        end
        chk("b2b_first_done", 128'(d1), 128'd10);
        chk("b2b_spacing", 128'(d2 - d1), 128'd11);
        chk("b2b_valid_end", 128'(bus.keys_valid), 128'd1);
        expand(kb);
        read_all("b2b");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, mis_cnt);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequential AES-128 key expansion controller. It iterates the single-round combinational key generator (`key_generation`, one round per clock) over rounds 1–10 and stores all 11 round keys (round 0 = cipher key) in an internal register file. It sits directly downstream of `key_generation` and upstream of the round datapath, which reads round keys by index.

## Interface
Parameters:
- None. The design is fixed to AES-128: 128-bit key, 10 rounds, 11 stored keys.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst_n`  in  1  Reset. Asynchronous, active-low.
- `start`  in  1  Request expansion of `key_in`. Sampled only in IDLE.
- `key_in`  in  128  Cipher key. Word w0 is bits [127:96].
- `busy`  out  1  High while in EXPAND.
- `done`  out  1  One-cycle pulse when round key 10 has been written.
- `keys_valid`  out  1  High when all 11 stored keys belong to the last accepted `key_in`.
- `rd_addr`  in  4  Round-key index, 0..10.
- `rd_data`  out  128  Combinational read of `rk[rd_addr]`. Reads 0 when `rd_addr` > 10.

## Operation
- Storage: `rk[0..10]`, 128 bits each. Working register `work` (128 bits). Round counter `rnd` (4 bits).
- One `key_generation` instance:
  - key input = `work`
  - round_num input = `rnd`
  - output = `next_key`
- State machine, states IDLE and EXPAND:
  - **IDLE, `start`=1:**
    - `rk[0]` ← `key_in`; `work` ← `key_in`; `rnd` ← 1
    - `keys_valid` ← 0; go to EXPAND
  - **IDLE, `start`=0:** hold all state.
  - **EXPAND, `rnd` < 10:**
    - `rk[rnd]` ← `next_key`; `work` ← `next_key`; `rnd` ← `rnd`+1
  - **EXPAND, `rnd` = 10:**
    - `rk[10]` ← `next_key`; `rnd` ← 0
    - `keys_valid` ← 1; `done` ← 1 for one cycle; go to IDLE
- `start` is ignored while in EXPAND. It is not queued, and `key_in` is not resampled.
- `key_in` only needs to be stable in the cycle where `start` is accepted.
- `busy` is decoded directly from the state (state == EXPAND).
- `rnd` never exceeds 10. The rcon values are 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10. They come from the generator; this block does not recompute them.
- A new `start` after `done` overwrites all entries. `keys_valid` drops in the cycle after the accepting edge and stays low until the new `done`.
- `rd_data` is not gated by `keys_valid`. During expansion it returns the current register contents, which are partial or stale. Consumers must wait for `keys_valid`.

## Timing
- Reset values:
  - state IDLE
  - `busy` = 0, `done` = 0, `keys_valid` = 0
  - `rnd` = 0, `work` = 0, all `rk` entries = 0
  - `rd_data` therefore reads 0
- Reset mid-EXPAND aborts immediately. All state returns to the reset values, and no `done` pulse is issued.
- Latency, with the accepting edge = E0:
  - `rk[k]` is written at edge Ek for k = 1..10.
  - `busy` is high from E0 through E10.
  - `done` and `keys_valid` rise after E10, i.e. 10 cycles after the `start` edge.
- Back-to-back operation: `start` held high continuously is accepted again in the first IDLE cycle after `done`. That cycle is the same cycle in which `done` is high. Each job therefore takes 11 cycles.
- Read path is purely combinational from `rk` and `rd_addr`, with zero latency.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → `busy`=0, `done`=0, `keys_valid`=0, `rd_data`=0 for every `rd_addr` 0..15.
- **FIPS-197 key:** `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start` → `done` 10 cycles later. Then read:
  - `rk[0]` = 2b7e151628aed2a6abf7158809cf4f3c
  - `rk[1]` = a0fafe1788542cb123a339392a6c7605
  - `rk[10]` = d014f9a8c9ee2589e13f0cc8b6630ca6
- **All-zero key:**
  - `rk[1]` = 62636363626363636263636362636363
  - `rk[10]` = b4ef5bcb3e92e21123e951cf6f8f188e
  - `rd_addr`=11..15 → 0.
- **Start during EXPAND:** pulse `start` with a different `key_in` at cycle 5 → ignored. Results equal the FIPS-197 vector, with exactly one `done` pulse.
- **Reset mid-operation:** drop `rst_n` at cycle 4 of expansion → all outputs and `rk` return to 0, no `done`. A restart then completes normally.
- **Back-to-back:** hold `start`=1 across two jobs with different keys → `done` pulses 11 cycles apart, and `keys_valid` is low between them.
